dmem_responder: RTL and testbench

- Memory-side responder for the CPU's MEM-stage data accesses.
- Accepts one load/store request at a time over a valid/ready handshake and inserts a parameterised number of wait states.
- Returns read data with a one-cycle response strobe and drives a stall request back to the pipeline until that response.
- Decodes a small MMIO window holding an LED register, a free-running cycle counter and a scratch register.

---
 rtl/dmem_responder_pkg.sv | 34 +++
 rtl/dmem_ram.sv | 40 ++++
 rtl/dmem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder_pkg
//  Description : Shared constants for the MEM-stage data responder: FSM state
//                encoding, MMIO window decode constants and a byte-merge
//                helper used by every byte-enabled storage element.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_responder_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Address bit selecting the MMIO window, and offsets inside that window
    localparam int         MMIO_BIT = 8;
    localparam logic [7:0] LED_OFS  = 8'h00;
    localparam logic [7:0] CYC_OFS  = 8'h04;
    localparam logic [7:0] SCR_OFS  = 8'h08;

    // Replace the bytes of old_w selected by be with the same bytes of new_w
    function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_ram
//  Description : 2^ADDR_W x 32 data RAM, synchronous byte-enabled write,
//                asynchronous read. Contents are not reset.
//  Ports       : clk      - clock
//                i_we     - write strobe
//                i_be     - byte enables (bit i -> bits 8i+7:8i)
//                i_addr   - word address (shared by read and write)
//                i_wdata  - write data
//                o_rdata  - read data at i_addr
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_ram #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : Memory-side responder for MEM-stage loads/stores. Accepts
//                one request at a time, inserts WAIT_CYCLES wait states,
//                returns a one-cycle response and decodes a small MMIO window
//                (LED register, cycle counter, scratch register).
//  Ports       : clk, reset            - clock, synchronous active-high reset
//                req_valid/req_we/req_addr/req_wdata/req_be - request
//                req_ready             - idle and accepting
//                resp_valid/resp_rdata/resp_err - response (strobe + data)
//                stall                 - pipeline hold request
//                led_out               - LED register contents
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 2,
    parameter int LED_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [3:0]       req_be,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             stall,
    output logic [LED_W-1:0] led_out
);

    localparam int               CNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    // RAM word-offset bits above the array depth must be zero
    localparam logic [7:0]       RAM_HI_MASK = 8'hFF << (ADDR_W + 2);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;

    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_be;

    logic [LED_W-1:0] r_led;
    logic [31:0]      r_cyc;
    logic [31:0]      r_scr;
    logic [31:0]      r_rdata;
    logic             r_err;

    logic             w_accept;
    logic             w_commit;
    logic             w_cur_we;
    logic [31:0]      w_cur_addr;
    logic [31:0]      w_cur_wdata;
    logic [3:0]       w_cur_be;
    logic [7:0]       w_ofs;
    logic             w_err;
    logic [31:0]      w_rdata;
    logic             w_ram_sel;
    logic             w_led_sel;
    logic             w_scr_sel;
    logic             w_ram_we;
    logic [31:0]      w_ram_rdata;
    logic [31:0]      w_led_merge;
    logic [31:0]      w_scr_merge;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (req_valid) w_next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt <= CNT_W'(1)) w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = (r_state == ST_RESP);
    end

    assign stall   = req_valid && !resp_valid;
    assign led_out = r_led;

    assign w_accept = (r_state == ST_IDLE) && req_valid;
    // The edge entering RESP performs the access; a reset on that edge cancels it.
    assign w_commit = (w_next_state == ST_RESP) && (r_state != ST_RESP) && !reset;

    // Wait-state counter and request latch
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= CNT_LOAD;
        end else if (r_state == ST_WAIT) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
        end
    end

    // With zero wait states the access happens on the accepting edge itself,
    // before the latch holds anything, so the live request is used in IDLE.
    assign w_cur_we    = (r_state == ST_IDLE) ? req_we    : r_we;
    assign w_cur_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
    assign w_cur_be    = (r_state == ST_IDLE) ? req_be    : r_be;
    assign w_ofs       = w_cur_addr[7:0];

    // ---------------- address decode ----------------
    always_comb begin
        w_err     = 1'b0;
        w_rdata   = '0;
        w_ram_sel = 1'b0;
        w_led_sel = 1'b0;
        w_scr_sel = 1'b0;
        if ((|w_cur_addr[1:0]) || (|w_cur_addr[31:9])) begin
            w_err = 1'b1;
        end else if (!w_cur_addr[MMIO_BIT]) begin
            if (|(w_ofs & RAM_HI_MASK)) begin
                w_err = 1'b1;
            end else begin
                w_ram_sel = 1'b1;
                w_rdata   = w_ram_rdata;
            end
        end else begin
            case (w_ofs)
                LED_OFS: begin
                    w_led_sel = 1'b1;
                    w_rdata   = 32'(r_led);
                end
                CYC_OFS: begin
                    w_err   = w_cur_we;
                    w_rdata = w_cur_we ? 32'd0 : r_cyc;
                end
                SCR_OFS: begin
                    w_scr_sel = 1'b1;
                    w_rdata   = r_scr;
                end
                default: w_err = 1'b1;
            endcase
        end
    end

    // ---------------- storage ----------------
    assign w_ram_we = w_commit && w_cur_we && w_ram_sel;

    dmem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_be    (w_cur_be),
        .i_addr  (w_cur_addr[ADDR_W+1:2]),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_ram_rdata)
    );

    assign w_led_merge = be_merge(32'(r_led), w_cur_wdata, w_cur_be);
    assign w_scr_merge = be_merge(r_scr, w_cur_wdata, w_cur_be);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led   <= '0;
            r_scr   <= '0;
            r_cyc   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (w_commit && w_cur_we && w_led_sel) r_led <= w_led_merge[LED_W-1:0];
            if (w_commit && w_cur_we && w_scr_sel) r_scr <= w_scr_merge;
            if (w_commit) begin
                r_rdata <= w_rdata;
                r_err   <= w_err;
            end
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Self-checking bench for dmem_responder. One instance with two
//                wait states takes the vector table and the multi-cycle
//                sequences; a zero-wait instance shares the request inputs and
//                is checked in the back-to-back sequence at the end.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;

    logic        rdy2, rv2, err2, stall2;
    logic [31:0] rd2;
    logic [15:0] led2;
    logic        rdy0, rv0, err0, stall0;
    logic [31:0] rd0;
    logic [15:0] led0;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int unsigned tb_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(2), .LED_W(16)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(rdy2), .resp_valid(rv2), .resp_rdata(rd2), .resp_err(err2),
        .stall(stall2), .led_out(led2)
    );

    dmem_responder #(.ADDR_W(6), .WAIT_CYCLES(0), .LED_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_ready(rdy0), .resp_valid(rv0), .resp_rdata(rd0), .resp_err(err0),
        .stall(stall0), .led_out(led0)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    // One transaction on the two-wait-state instance. Returns response data,
    // error, latency in cycles after the accepting edge, stall violations and
    // the bench cycle count at the response.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rd, output logic e,
                        output int lat, output int stall_bad, output int unsigned cyc);
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        lat = 0; stall_bad = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rv2 && !stall2) stall_bad++;
        end while (!rv2 && lat < 20);
        if (rv2 && stall2) stall_bad++;
        rd = rd2; e = err2; cyc = tb_cyc;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, c1, c2, c3;
        logic        e;
        int          lat, sb;
        int unsigned t1, t2, t3;
        int          bad;

        //          we    addr           wdata          be       chk   exp_rd         err   led
        vecs.push_back('{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,         1'b0, 16'h0000});
        vecs.push_back('{1'b0, 32'h0000_0010, 32'h0,         4'b0000, 1'b1, 32'hDEAD_BEEF, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 32'h0000_0014, 32'h1122_3344, 4'b1111, 1'b0, 32'h0,         1'b0, 16'h0000});
        vecs.push_back('{1'b1, 32'h0000_0014, 32'h0000_AA00, 4'b0010, 1'b0, 32'h0,         1'b0, 16'h0000});
        vecs.push_back('{1'b0, 32'h0000_0014, 32'h0,         4'b0000, 1'b1, 32'h1122_AA44, 1'b0, 16'h0000});
        vecs.push_back('{1'b1, 32'h0000_0100, 32'h0000_1234, 4'b1111, 1'b0, 32'h0,         1'b0, 16'h1234});
        vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 1'b1, 32'h0000_1234, 1'b0, 16'h1234});
        vecs.push_back('{1'b1, 32'h0000_0100, 32'hFFFF_ABCD, 4'b0001, 1'b0, 32'h0,         1'b0, 16'h12CD});
        vecs.push_back('{1'b0, 32'h0000_0100, 32'h0,         4'b0000, 1'b1, 32'h0000_12CD, 1'b0, 16'h12CD});
        vecs.push_back('{1'b1, 32'h0000_0108, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0,         1'b0, 16'h12CD});
        vecs.push_back('{1'b1, 32'h0000_0108, 32'h0000_00FF, 4'b0001, 1'b0, 32'h0,         1'b0, 16'h12CD});
        vecs.push_back('{1'b0, 32'h0000_0108, 32'h0,         4'b0000, 1'b1, 32'hCAFE_F0FF, 1'b0, 16'h12CD});
        vecs.push_back('{1'b0, 32'h0000_0012, 32'h0,         4'b0000, 1'b1, 32'h0,         1'b1, 16'h12CD});
        vecs.push_back('{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'b1111, 1'b0, 32'h0,         1'b0, 16'h12CD});
        vecs.push_back('{1'b1, 32'h0000_0200, 32'h0000_0055, 4'b1111, 1'b0, 32'h0,         1'b1, 16'h12CD});
        vecs.push_back('{1'b0, 32'h0000_0000, 32'h0,         4'b0000, 1'b1, 32'hA5A5_A5A5, 1'b0, 16'h12CD});
        vecs.push_back('{1'b0, 32'h0000_010C, 32'h0,         4'b0000, 1'b1, 32'h0,         1'b1, 16'h12CD});
        vecs.push_back('{1'b1, 32'h0000_0104, 32'h0,         4'b1111, 1'b0, 32'h0,         1'b1, 16'h12CD});
        vecs.push_back('{1'b1, 32'h0000_0018, 32'h0BAD_F00D, 4'b1111, 1'b0, 32'h0,         1'b0, 16'h12CD});
        vecs.push_back('{1'b1, 32'h0000_0018, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'h0,         1'b0, 16'h12CD});
        vecs.push_back('{1'b0, 32'h0000_0018, 32'h0,         4'b0000, 1'b1, 32'h0BAD_F00D, 1'b0, 16'h12CD});
        vecs.push_back('{1'b0, 32'h0000_0400, 32'h0,         4'b0000, 1'b1, 32'h0,         1'b1, 16'h12CD});
        vecs.push_back('{1'b0, 32'h8000_0010, 32'h0,         4'b0000, 1'b1, 32'h0,         1'b1, 16'h12CD});

        // ---------------- reset ----------------
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(rdy2), 32'd1);
        chk("rst_stall", 32'(stall2), 32'd0);
        chk("rst_led", 32'(led2), 32'd0);
        chk("rst_resp_valid", 32'(rv2), 32'd0);
        chk("rst_rdata", rd2, 32'd0);
        chk("rst_err", 32'(err2), 32'd0);

        // ---------------- vector table ----------------
        foreach (vecs[i]) begin
            xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, e, lat, sb, t1);
            chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd3);
            chk($sformatf("v%0d_stall", i), 32'(sb), 32'd0);
            chk($sformatf("v%0d_led", i), 32'(led2), 32'(vecs[i].exp_led));
        end

        // ---------------- cycle counter ----------------
        xact(1'b0, 32'h104, 32'h0, 4'h0, c1, e, lat, sb, t1);
        repeat (7) @(negedge clk);
        xact(1'b0, 32'h104, 32'h0, 4'h0, c2, e, lat, sb, t2);
        chk("cyc_delta", c2 - c1, 32'(t2 - t1));
        xact(1'b1, 32'h104, 32'h0, 4'hF, rd, e, lat, sb, t3);
        chk("cyc_store_err", 32'(e), 32'd1);
        xact(1'b0, 32'h104, 32'h0, 4'h0, c3, e, lat, sb, t3);
        chk("cyc_delta_after_store", c3 - c2, 32'(t3 - t2));

        // ---------------- reset during WAIT ----------------
        xact(1'b1, 32'h20, 32'h1111_1111, 4'hF, rd, e, lat, sb, t1);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0000_0077; req_be = 4'hF;
        req_valid = 1'b1;
        @(negedge clk);
        chk("midrst_accepted", 32'(rdy2), 32'd0);
        reset = 1'b1; req_valid = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rv2) bad++;
        end
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rv2) bad++;
        end
        chk("midrst_no_resp", 32'(bad), 32'd0);
        chk("midrst_idle", 32'(rdy2), 32'd1);
        chk("midrst_led", 32'(led2), 32'd0);
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat, sb, t1);
        chk("midrst_old_data", rd, 32'h1111_1111);

        // ---------------- zero wait states, back-to-back ----------------
        repeat (2) @(negedge clk);
        chk("w0_idle_ready", 32'(rdy0), 32'd1);
        req_we = 1'b1; req_addr = 32'h108; req_wdata = 32'h1234_5678; req_be = 4'hF;
        req_valid = 1'b1;
        #1;
        chk("w0_a_stall_wait", 32'(stall0), 32'd1);
        @(negedge clk);
        chk("w0_a_resp", 32'(rv0), 32'd1);
        chk("w0_a_stall_resp", 32'(stall0), 32'd0);
        chk("w0_a_err", 32'(err0), 32'd0);
        req_we = 1'b0; req_addr = 32'h108; req_wdata = 32'h0; req_be = 4'h0;
        @(negedge clk);
        chk("w0_gap_resp", 32'(rv0), 32'd0);
        chk("w0_gap_ready", 32'(rdy0), 32'd1);
        chk("w0_gap_stall", 32'(stall0), 32'd1);
        @(negedge clk);
        chk("w0_b_resp", 32'(rv0), 32'd1);
        chk("w0_b_stall_resp", 32'(stall0), 32'd0);
        chk("w0_b_rdata", rd0, 32'h1234_5678);
        chk("w0_b_err", 32'(err0), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("w0_end_resp", 32'(rv0), 32'd0);
        chk("w0_end_stall", 32'(stall0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
